// File: rtl/instr_decoder_pipe.sv
// Pipelined, handshaked instruction decoder for the 8-bit micro-controller core.
// One instruction register sits between fetch and the datapath. Decode is
// combinational from that register and is only driven while the instruction
// issues. A taken jump can squash the instruction fetched behind it, and
// issued NOP-class opcodes are tallied in a saturating counter.
module instr_decoder_pipe #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          FLUSH_ON_JMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             stall,
  input  logic             zero_flag,
  input  logic             clr_count,
  output logic [7:0]       ir,
  output logic             ir_valid,
  output logic [3:0]       ir_nibble,
  output logic [3:0]       source_sel,
  output logic [8:0]       reg_en,
  output logic [7:0]       from_ID,
  output logic             i_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic             jmp,
  output logic             jmp_nz,
  output logic             jmp_taken,
  output logic [3:0]       nop_detect,
  output logic [CNT_W-1:0] nop_count
);

  // Source-select codes with fixed meaning on the datapath mux.
  localparam logic [3:0] SrcLoadImm = 4'd8;
  localparam logic [3:0] SrcSelf    = 4'd9;
  localparam logic [3:0] SrcReset   = 4'd10;
  localparam logic [3:0] SrcFour    = 4'd4;

  // NOP-class opcodes, in nop_detect bit order.
  localparam logic [7:0] OpNop0 = 8'hC8;
  localparam logic [7:0] OpNop1 = 8'hCF;
  localparam logic [7:0] OpNop2 = 8'hD8;
  localparam logic [7:0] OpNop3 = 8'hDF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]       r_ir;
  logic             r_ir_valid;
  logic             r_squash_pend;
  logic [CNT_W-1:0] r_nop_count;

  // ---------------------------------------------------------------------------
  // Handshake / issue qualifiers
  // ---------------------------------------------------------------------------
  logic w_ready;
  logic w_accept;
  logic w_issue;
  logic w_squash_req;

  // Raw decode of r_ir, before issue qualification.
  logic [8:0] w_dec_reg_en;
  logic [3:0] w_dec_src;
  logic       w_dec_i_sel;
  logic       w_dec_x_sel;
  logic       w_dec_y_sel;
  logic       w_dec_jmp;
  logic       w_dec_jmp_nz;
  logic [3:0] w_dec_nop;
  logic       w_jmp_taken;

  assign w_ready  = reset_n & ~stall;
  assign w_accept = instr_valid & w_ready;
  assign w_issue  = r_ir_valid & ~stall & reset_n;

  // A taken jump needs issue; jmp_nz only counts when the zero flag is clear.
  assign w_jmp_taken = w_issue & (w_dec_jmp | (w_dec_jmp_nz & ~zero_flag));

  // Squash the next accepted instruction now, or remember it if nothing arrives.
  assign w_squash_req = FLUSH_ON_JMP & (w_jmp_taken | r_squash_pend);

  // Map a 3-bit destination code onto the register-enable vector.
  function automatic logic [8:0] dst_enable(input logic [2:0] d);
    logic [8:0] en;
    en = 9'h000;
    unique case (d)
      3'd0: en[0] = 1'b1;
      3'd1: en[1] = 1'b1;
      3'd2: en[2] = 1'b1;
      3'd3: en[3] = 1'b1;
      3'd4: en[8] = 1'b1;
      3'd5: en[5] = 1'b1;
      3'd6: en[6] = 1'b1;
      3'd7: begin
        en[7] = 1'b1;
        en[6] = 1'b1;
      end
      default: en = 9'h000;
    endcase
    return en;
  endfunction

  // Instruction register, valid bit and pending-squash flag; all hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir          <= 8'h00;
      r_ir_valid    <= 1'b0;
      r_squash_pend <= 1'b0;
    end else if (w_ready) begin
      if (w_accept) begin
        r_ir          <= instr_in;
        r_ir_valid    <= ~w_squash_req;
        r_squash_pend <= 1'b0;
      end else begin
        r_ir_valid    <= 1'b0;
        r_squash_pend <= w_squash_req;
      end
    end
  end

  // Opcode decode of the held instruction, independent of issue.
  always_comb begin
    w_dec_reg_en = 9'h000;
    w_dec_src    = 4'd0;
    w_dec_i_sel  = 1'b1;
    w_dec_x_sel  = 1'b0;
    w_dec_y_sel  = 1'b0;
    w_dec_jmp    = 1'b0;
    w_dec_jmp_nz = 1'b0;
    if (!r_ir[7]) begin
      // 0ddd_iiii: load immediate
      w_dec_reg_en = dst_enable(r_ir[6:4]);
      w_dec_src    = SrcLoadImm;
      w_dec_i_sel  = (r_ir[6:4] != 3'd6);
    end else if (!r_ir[6]) begin
      // 10dd_dsss: register move
      w_dec_reg_en = dst_enable(r_ir[5:3]);
      if (r_ir[2:0] == 3'd7) begin
        w_dec_reg_en[6] = 1'b1;
      end
      if (r_ir[2:0] == 3'd4) begin
        w_dec_src = SrcFour;
      end else if (r_ir[5:3] == r_ir[2:0]) begin
        w_dec_src = SrcSelf;
      end else begin
        w_dec_src = {1'b0, r_ir[2:0]};
      end
      w_dec_i_sel = (r_ir[5:3] != 3'd6);
    end else if (!r_ir[5]) begin
      // 110x_yfff: ALU operation into r
      w_dec_reg_en[4] = 1'b1;
      w_dec_x_sel     = r_ir[4];
      w_dec_y_sel     = r_ir[3];
      w_dec_src       = {1'b0, r_ir[2:0]};
    end else begin
      // 1110_xxxx jmp, 1111_xxxx jmp_nz
      w_dec_jmp    = ~r_ir[4];
      w_dec_jmp_nz = r_ir[4];
      w_dec_src    = {1'b0, r_ir[2:0]};
    end
  end

  // NOP-class match of the held instruction.
  always_comb begin
    w_dec_nop[0] = (r_ir == OpNop0);
    w_dec_nop[1] = (r_ir == OpNop1);
    w_dec_nop[2] = (r_ir == OpNop2);
    w_dec_nop[3] = (r_ir == OpNop3);
  end

  // Drive the datapath: reset pattern, issued decode, or all-quiet.
  always_comb begin
    reg_en     = 9'h000;
    source_sel = 4'd0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    jmp_taken  = 1'b0;
    nop_detect = 4'b0000;
    if (!reset_n) begin
      reg_en     = 9'h1FF;
      source_sel = SrcReset;
    end else if (w_issue) begin
      reg_en     = w_dec_reg_en;
      source_sel = w_dec_src;
      i_sel      = w_dec_i_sel;
      x_sel      = w_dec_x_sel;
      y_sel      = w_dec_y_sel;
      jmp        = w_dec_jmp;
      jmp_nz     = w_dec_jmp_nz;
      jmp_taken  = w_jmp_taken;
      nop_detect = w_dec_nop;
    end
  end

  // Saturating count of issued NOP-class instructions; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nop_count <= '0;
    end else if (clr_count) begin
      r_nop_count <= '0;
    end else if (w_issue && (w_dec_nop != 4'b0000) && !(&r_nop_count)) begin
      r_nop_count <= r_nop_count + 1'b1;
    end
  end

  assign instr_ready = w_ready;
  assign ir          = r_ir;
  assign ir_valid    = r_ir_valid;
  assign ir_nibble   = r_ir[3:0];
  assign from_ID     = reg_en[7:0];
  assign nop_count   = r_nop_count;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe. Inputs change on the falling edge and
// outputs are checked 1ns later; a second instance with a 2-bit counter shares
// all inputs to cover counter saturation.
module tb_instr_decoder_pipe;

  logic       clk;
  logic       reset_n;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       stall;
  logic       zero_flag;
  logic       clr_count;

  logic        instr_ready, ir_valid, i_sel, x_sel, y_sel, jmp, jmp_nz, jmp_taken;
  logic [7:0]  ir, from_ID;
  logic [3:0]  ir_nibble, source_sel, nop_detect;
  logic [8:0]  reg_en;
  logic [15:0] nop_count;

  logic        s_instr_ready, s_ir_valid, s_i_sel, s_x_sel, s_y_sel;
  logic        s_jmp, s_jmp_nz, s_jmp_taken;
  logic [7:0]  s_ir, s_from_ID;
  logic [3:0]  s_ir_nibble, s_source_sel, s_nop_detect;
  logic [8:0]  s_reg_en;
  logic [1:0]  s_nop_count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_decoder_pipe #(.CNT_W(16), .FLUSH_ON_JMP(1'b1)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .stall      (stall),
    .zero_flag  (zero_flag),
    .clr_count  (clr_count),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_nibble  (ir_nibble),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .from_ID    (from_ID),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_taken  (jmp_taken),
    .nop_detect (nop_detect),
    .nop_count  (nop_count)
  );

  instr_decoder_pipe #(.CNT_W(2), .FLUSH_ON_JMP(1'b1)) u_dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(s_instr_ready),
    .stall      (stall),
    .zero_flag  (zero_flag),
    .clr_count  (clr_count),
    .ir         (s_ir),
    .ir_valid   (s_ir_valid),
    .ir_nibble  (s_ir_nibble),
    .source_sel (s_source_sel),
    .reg_en     (s_reg_en),
    .from_ID    (s_from_ID),
    .i_sel      (s_i_sel),
    .x_sel      (s_x_sel),
    .y_sel      (s_y_sel),
    .jmp        (s_jmp),
    .jmp_nz     (s_jmp_nz),
    .jmp_taken  (s_jmp_taken),
    .nop_detect (s_nop_detect),
    .nop_count  (s_nop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and present new inputs.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    instr_valid = v;
    instr_in    = d;
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_in    = 8'h00;
    instr_valid = 1'b0;
    stall       = 1'b0;
    zero_flag   = 1'b0;
    clr_count   = 1'b0;
    #1;
    check_eq("rst_reg_en", {23'd0, reg_en}, 32'h1FF);
    check_eq("rst_src", {28'd0, source_sel}, 32'd10);
    check_eq("rst_ready", {31'd0, instr_ready}, 32'd0);
    check_eq("rst_ir", {24'd0, ir}, 32'h00);
    check_eq("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("rst_count", {16'd0, nop_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("idle_reg_en", {23'd0, reg_en}, 32'h000);
    check_eq("idle_ready", {31'd0, instr_ready}, 32'd1);

    // Back-to-back stream: each check sees the instruction accepted one edge earlier.
    drive(1'b1, 8'h05);
    drive(1'b1, 8'h9A);
    check_eq("ld05_reg_en", {23'd0, reg_en}, 32'h001);
    check_eq("ld05_src", {28'd0, source_sel}, 32'd8);
    check_eq("ld05_i_sel", {31'd0, i_sel}, 32'd1);
    check_eq("ld05_nibble", {28'd0, ir_nibble}, 32'd5);
    drive(1'b1, 8'hD3);
    check_eq("mv9a_reg_en", {23'd0, reg_en}, 32'h008);
    check_eq("mv9a_src", {28'd0, source_sel}, 32'd2);
    drive(1'b1, 8'hBF);
    check_eq("alud3_reg_en", {23'd0, reg_en}, 32'h010);
    check_eq("alud3_xy", {30'd0, x_sel, y_sel}, 32'b10);
    check_eq("alud3_src", {28'd0, source_sel}, 32'd3);
    check_eq("alud3_nop", {28'd0, nop_detect}, 32'd0);
    drive(1'b1, 8'hA4);
    check_eq("mvbf_reg_en", {23'd0, reg_en}, 32'h0C0);
    check_eq("mvbf_src", {28'd0, source_sel}, 32'd9);
    check_eq("mvbf_from_id", {24'd0, from_ID}, 32'hC0);
    drive(1'b1, 8'h12);
    check_eq("mva4_reg_en", {23'd0, reg_en}, 32'h100);
    check_eq("mva4_src", {28'd0, source_sel}, 32'd4);
    check_eq("mva4_from_id", {24'd0, from_ID}, 32'h00);

    // Stall three cycles with 8'h12 held in ir.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall       = 1'b1;
      instr_valid = 1'b1;
      instr_in    = 8'h77;
      #1;
      check_eq("stall_reg_en", {23'd0, reg_en}, 32'h000);
      check_eq("stall_ready", {31'd0, instr_ready}, 32'd0);
      check_eq("stall_ir", {24'd0, ir}, 32'h12);
    end
    @(negedge clk);
    stall = 1'b0;
    instr_valid = 1'b0;
    #1;
    check_eq("post_stall_reg_en", {23'd0, reg_en}, 32'h002);
    drive(1'b0, 8'h00);
    check_eq("bubble_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("bubble_reg_en", {23'd0, reg_en}, 32'h000);

    // Taken jmp squashes the instruction accepted behind it.
    drive(1'b1, 8'hE5);
    drive(1'b1, 8'h01);
    check_eq("jmp_jmp", {31'd0, jmp}, 32'd1);
    check_eq("jmp_taken", {31'd0, jmp_taken}, 32'd1);
    check_eq("jmp_src", {28'd0, source_sel}, 32'd5);
    drive(1'b0, 8'h00);
    check_eq("sq_ir", {24'd0, ir}, 32'h01);
    check_eq("sq_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("sq_reg_en", {23'd0, reg_en}, 32'h000);

    // Untaken jmp_nz: follower issues normally.
    drive(1'b1, 8'hF5);
    drive(1'b1, 8'h01);
    zero_flag = 1'b1;
    #1;
    check_eq("jnz_flag", {31'd0, jmp_nz}, 32'd1);
    check_eq("jnz_taken", {31'd0, jmp_taken}, 32'd0);
    drive(1'b0, 8'h00);
    zero_flag = 1'b0;
    #1;
    check_eq("jnz_follow_valid", {31'd0, ir_valid}, 32'd1);
    check_eq("jnz_follow_reg_en", {23'd0, reg_en}, 32'h001);

    // NOP-class counting: C8, CF, D8, DF count, C9 does not.
    drive(1'b1, 8'hC8);
    drive(1'b1, 8'hCF);
    check_eq("nop_c8", {28'd0, nop_detect}, 32'b0001);
    drive(1'b1, 8'hD8);
    check_eq("nop_cf", {28'd0, nop_detect}, 32'b0010);
    drive(1'b1, 8'hDF);
    check_eq("nop_d8", {28'd0, nop_detect}, 32'b0100);
    drive(1'b1, 8'hC9);
    check_eq("nop_df", {28'd0, nop_detect}, 32'b1000);
    drive(1'b0, 8'h00);
    check_eq("nop_c9", {28'd0, nop_detect}, 32'b0000);
    drive(1'b1, 8'hC8);
    check_eq("count4", {16'd0, nop_count}, 32'd4);
    check_eq("count_sat_a", {30'd0, s_nop_count}, 32'd3);
    drive(1'b1, 8'hC8);
    @(negedge clk);
    instr_valid = 1'b0;
    clr_count   = 1'b1;
    #1;
    check_eq("count5", {16'd0, nop_count}, 32'd5);
    check_eq("count_sat_b", {30'd0, s_nop_count}, 32'd3);
    check_eq("clr_nop_issue", {28'd0, nop_detect}, 32'b0001);
    @(negedge clk);
    clr_count = 1'b0;
    #1;
    check_eq("count_clr", {16'd0, nop_count}, 32'd0);
    check_eq("count_clr_sat", {30'd0, s_nop_count}, 32'd0);

    // Leave a squash pending, stall, then reset mid-stall.
    drive(1'b1, 8'hE5);
    drive(1'b0, 8'h00);
    check_eq("pend_jmp_taken", {31'd0, jmp_taken}, 32'd1);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_reg_en", {23'd0, reg_en}, 32'h1FF);
    check_eq("midrst_src", {28'd0, source_sel}, 32'd10);
    check_eq("midrst_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stall   = 1'b0;
    #1;
    check_eq("postrst_ir_valid", {31'd0, ir_valid}, 32'd0);
    drive(1'b1, 8'h12);
    drive(1'b0, 8'h00);
    check_eq("postrst_first_valid", {31'd0, ir_valid}, 32'd1);
    check_eq("postrst_first_reg_en", {23'd0, reg_en}, 32'h002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_decoder_pipe.md
Name: instr_decoder_pipe

Overview:
Pipelined, handshaked instruction decoder for the 8-bit micro-controller core. It sits between instruction fetch (program memory/PC) and the datapath register file/ALU. It adds a valid/ready fetch handshake, stall support, optional squash of the instruction after a taken jump, and a saturating counter of issued NOP-class instructions (C8, CF, D8, DF).

Parameters:
CNT_W, 16, width of nop_count.
FLUSH_ON_JMP, 1, 1 = squash the instruction accepted in the same cycle a jump is taken; 0 = no squash.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous reset, active-low.
instr_in  input  8  next instruction from program memory.
instr_valid  input  1  instr_in is valid.
instr_ready  output  1  decoder can accept instr_in this cycle.
stall  input  1  datapath stall; holds ir and suppresses issue.
zero_flag  input  1  ALU zero flag; used to resolve jmp_nz.
clr_count  input  1  synchronous clear of nop_count.
ir  output  8  instruction register.
ir_valid  output  1  ir holds a live, unsquashed instruction.
ir_nibble  output  4  ir[3:0] (immediate / jump target).
source_sel  output  4  datapath source mux select.
reg_en  output  9  bit8 o_reg, bit7 dm, bit6 i, bit5 m, bit4 r, bit3 y1, bit2 y0, bit1 x1, bit0 x0.
from_ID  output  8  reg_en[7:0].
i_sel, x_sel, y_sel  output  1 each  i-increment select, ALU x/y operand selects.
jmp, jmp_nz  output  1 each  unconditional / conditional jump decoded at issue.
jmp_taken  output  1  jmp, or jmp_nz with zero_flag==0, at issue.
nop_detect  output  4  {ir==DF, ir==D8, ir==CF, ir==C8}, qualified by issue.
nop_count  output  CNT_W  count of issued NOP-class instructions.

Behaviour:
- Reset (reset_n=0, async): ir=8'h00, ir_valid=0, squash state cleared, nop_count=0. While reset_n=0, outputs are forced combinationally to reg_en=9'h1FF, source_sel=10, i_sel=x_sel=y_sel=0, jmp=jmp_nz=jmp_taken=0, nop_detect=0, instr_ready=0.
- Handshake: instr_ready = reset_n & ~stall. Accept = instr_valid & instr_ready. On accept: ir<=instr_in, ir_valid<=1 (or 0 if squashed). When ready is high and nothing is accepted: ir_valid<=0 (bubble). When stall=1: ir and ir_valid hold.
- Issue = ir_valid & ~stall & reset_n. Each instruction issues exactly once. Latency: 1 clock from accept to issue.
- When not issuing: reg_en=0, jmp/jmp_nz/jmp_taken=0, nop_detect=0, source_sel=0, selects=0.
- Decode at issue:
  - 0ddd_iiii (load): source_sel=8, enable dst d.
  - 10ddd_sss (move): enable dst d; also reg_en[6]=1 if s==7. source_sel=4 if s==4; else 9 if d==s; else {0,s}.
  - 110x_yfff (ALU): reg_en[4]=1, x_sel=ir[4], y_sel=ir[3], source_sel={0,ir[2:0]}.
  - 1110 (jmp): jmp=1. 1111 (jmp_nz): jmp_nz=1. source_sel={0,ir[2:0]}.
  - Dst map: d=0..3 → bits 0..3; d=4 → bit8; d=5 → bit5; d=6 → bit6; d=7 → bits 7 and 6.
  - i_sel=0 if load/move dst==6, else 1 for any issued instruction.
- Squash: if FLUSH_ON_JMP=1 and jmp_taken=1, the instruction accepted in that same cycle is loaded with ir_valid=0. If no accept occurs that cycle, the squash remains pending and applies to the next accepted instruction. jmp_nz not taken → no squash.
- nop_count: +1 per issue with any nop_detect bit set. Saturates at all-ones. clr_count has priority over increment on the same cycle.
- Reset mid-stall or mid-squash: all state cleared. The first instruction accepted after reset is not squashed.

Test Plan:
- Reset then stream 8'h05, 8'h9A, 8'hD3 with valid=1 → issue cycles 1, 2, 3:
  - reg_en=0x001, source_sel=8
  - reg_en=0x008, source_sel=2
  - reg_en=0x010, y_sel=0, x_sel=1, source_sel=3
- Move 8'hBF (d=7, s=7) → reg_en=0x0C0, source_sel=9. Move 8'hA4 → reg_en=0x100, source_sel=4.
- Stall=1 for 3 cycles with 8'h12 in ir → reg_en=0 and instr_ready=0 during stall; 8'h12 issues once (reg_en=0x002) after stall drops.
- FLUSH_ON_JMP=1: 8'hE5 followed by 8'h01 → jmp_taken=1; next cycle ir=8'h01 with ir_valid=0, no enables. Repeat with 8'hF5 and zero_flag=1 → not taken, 8'h01 issues.
- Issue C8, CF, D8, DF, C9 → nop_count=4. With CNT_W=2, issue 5 NOPs → count saturates at 3. Assert clr_count together with a NOP issue → count=0.
- Pull reset_n low during stall with squash pending → outputs immediately take reset pattern (reg_en=9'h1FF, source_sel=10); after release, ir_valid=0 and the first accepted instruction issues normally.
